// File: rtl/reg_file_sb.sv
// Parametrised register file with two combinational read ports, one write port,
// optional writeback bypass / hardwired zero register, and a busy-bit scoreboard.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [ADDR_W-1:0]      RS_ID,
  input  logic [ADDR_W-1:0]      RT_ID,
  output logic [DATA_W-1:0]      Reg_RData1,
  output logic [DATA_W-1:0]      Reg_RData2,
  input  logic [ADDR_W-1:0]      REG_W_ID,
  input  logic                   Reg_WE,
  input  logic [DATA_W-1:0]      Reg_WData,
  input  logic                   Issue_Valid,
  input  logic                   Issue_WE,
  input  logic [ADDR_W-1:0]      Issue_WID,
  output logic                   Issue_Accept,
  output logic                   Hazard,
  output logic [2**ADDR_W-1:0]   Busy_Vec
);

  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam bit          ZR_EN  = (ZERO_REG != 0);
  localparam bit          BYP_EN = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  eff_busy_c;
  logic              wr_en_c;
  logic              byp1_c, byp2_c;
  logic              zero1_c, zero2_c;
  logic              claim_c;

  // Writes to the hardwired zero register are dropped.
  assign wr_en_c = Reg_WE & ~(ZR_EN && (REG_W_ID == '0));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs_q[REG_W_ID] <= Reg_WData;
    end
  end

  // Read ports: zero register beats bypass, bypass beats the array.
  always_comb begin
    zero1_c = ZR_EN && (RS_ID == '0);
    zero2_c = ZR_EN && (RT_ID == '0);
    byp1_c  = BYP_EN && wr_en_c && (REG_W_ID == RS_ID);
    byp2_c  = BYP_EN && wr_en_c && (REG_W_ID == RT_ID);
    if (zero1_c)     Reg_RData1 = '0;
    else if (byp1_c) Reg_RData1 = Reg_WData;
    else             Reg_RData1 = regs_q[RS_ID];
    if (zero2_c)     Reg_RData2 = '0;
    else if (byp2_c) Reg_RData2 = Reg_WData;
    else             Reg_RData2 = regs_q[RT_ID];
  end

  // A writeback in flight this cycle hides the busy bit when bypass is enabled.
  always_comb begin
    eff_busy_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      eff_busy_c[i] = busy_q[i] & ~(BYP_EN && Reg_WE && (REG_W_ID == ADDR_W'(i)));
    end
    if (ZR_EN) begin
      eff_busy_c[0] = 1'b0;
    end
  end

  assign Hazard       = Issue_Valid & (eff_busy_c[RS_ID] | eff_busy_c[RT_ID] |
                                       (Issue_WE & eff_busy_c[Issue_WID]));
  assign Issue_Accept = Issue_Valid & ~Hazard;
  assign claim_c      = Issue_Accept & Issue_WE & ~(ZR_EN && (Issue_WID == '0));

  // Clear on writeback first, then set on claim so a same-cycle claim survives.
  always_comb begin
    busy_d = busy_q;
    if (Reg_WE) begin
      busy_d[REG_W_ID] = 1'b0;
    end
    if (claim_c) begin
      busy_d[Issue_WID] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign Busy_Vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: instance 0 uses defaults (bypass, no zero reg),
// instance 1 uses ZERO_REG=1, BYPASS=0.
module tb_reg_file_sb;

  typedef struct packed {
    logic        sel;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        haz;
    logic        acc;
    logic [7:0]  busy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  rs    [2];
  logic [2:0]  rt    [2];
  logic [2:0]  wid   [2];
  logic        we    [2];
  logic [15:0] wdata [2];
  logic        iv    [2];
  logic        iwe   [2];
  logic [2:0]  iwid  [2];
  logic [15:0] rd1   [2];
  logic [15:0] rd2   [2];
  logic        acc   [2];
  logic        haz   [2];
  logic [7:0]  busy  [2];

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  reg_file_sb u_dut_a (
    .CLK(clk), .RST(rst), .RS_ID(rs[0]), .RT_ID(rt[0]),
    .Reg_RData1(rd1[0]), .Reg_RData2(rd2[0]),
    .REG_W_ID(wid[0]), .Reg_WE(we[0]), .Reg_WData(wdata[0]),
    .Issue_Valid(iv[0]), .Issue_WE(iwe[0]), .Issue_WID(iwid[0]),
    .Issue_Accept(acc[0]), .Hazard(haz[0]), .Busy_Vec(busy[0])
  );

  reg_file_sb #(.ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .CLK(clk), .RST(rst), .RS_ID(rs[1]), .RT_ID(rt[1]),
    .Reg_RData1(rd1[1]), .Reg_RData2(rd2[1]),
    .REG_W_ID(wid[1]), .Reg_WE(we[1]), .Reg_WData(wdata[1]),
    .Issue_Valid(iv[1]), .Issue_WE(iwe[1]), .Issue_WID(iwid[1]),
    .Issue_Accept(acc[1]), .Hazard(haz[1]), .Busy_Vec(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      rs[k] = '0; rt[k] = '0; wid[k] = '0; we[k] = 1'b0; wdata[k] = '0;
      iv[k] = 1'b0; iwe[k] = 1'b0; iwid[k] = '0;
    end
  endtask

  task automatic drv(input int k, input logic [2:0] r1, input logic [2:0] r2,
                     input logic w_en, input logic [2:0] w_id, input logic [15:0] w_d,
                     input logic v, input logic ie, input logic [2:0] iw);
    rs[k] = r1; rt[k] = r2; we[k] = w_en; wid[k] = w_id; wdata[k] = w_d;
    iv[k] = v; iwe[k] = ie; iwid[k] = iw;
  endtask

  task automatic exp_push(input int k, input logic [15:0] e1, input logic [15:0] e2,
                          input logic eh, input logic ea, input logic [7:0] eb);
    exp_t e;
    e.sel = k[0]; e.rd1 = e1; e.rd2 = e2; e.haz = eh; e.acc = ea; e.busy = eb;
    q.push_back(e);
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, req, $time);
  endtask

  // Monitor: every expectation queued for this cycle is compared mid-cycle.
  initial begin
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        k = int'(e.sel);
        check("rdata1", k, 32'(rd1[k]),  32'(e.rd1));
        check("rdata2", k, 32'(rd2[k]),  32'(e.rd2));
        check("hazard", k, 32'(haz[k]),  32'(e.haz));
        check("accept", k, 32'(acc[k]),  32'(e.acc));
        check("busy",   k, 32'(busy[k]), 32'(e.busy));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_all();
    @(posedge clk);
    #1;

    // In reset: reads zero, accept follows valid, no state update on the edge.
    drv(0, 3'd0, 3'd7, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 3'd5);
    exp_push(0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h00);
    drv(1, 3'd3, 3'd4, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    exp_push(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);
    cyc();
    rst = 1'b0;

    // Write R3 with same-cycle bypass, then read back from the array.
    drv(0, 3'd3, 3'd5, 1'b1, 3'd3, 16'h007B, 1'b0, 1'b0, 3'd0);
    exp_push(0, 16'h007B, 16'h0000, 1'b0, 1'b0, 8'h00);
    cyc();
    drv(0, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    exp_push(0, 16'h007B, 16'h007B, 1'b0, 1'b0, 8'h00);
    cyc();

    // Claim R5, then RAW stall on R5, then bypassed writeback clears it.
    drv(0, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 3'd5);
    exp_push(0, 16'h007B, 16'h007B, 1'b0, 1'b1, 8'h00);
    cyc();
    drv(0, 3'd5, 3'd3, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 3'd6);
    exp_push(0, 16'h0000, 16'h007B, 1'b1, 1'b0, 8'h20);
    cyc();
    drv(0, 3'd5, 3'd3, 1'b1, 3'd5, 16'h1234, 1'b1, 1'b1, 3'd6);
    exp_push(0, 16'h1234, 16'h007B, 1'b0, 1'b1, 8'h20);
    cyc();
    drv(0, 3'd5, 3'd6, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    exp_push(0, 16'h1234, 16'h0000, 1'b0, 1'b0, 8'h40);
    cyc();

    // Same-cycle writeback and claim of R2: the claim survives.
    drv(0, 3'd0, 3'd0, 1'b1, 3'd2, 16'h00AA, 1'b1, 1'b1, 3'd2);
    exp_push(0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h40);
    cyc();
    drv(0, 3'd2, 3'd6, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0);
    exp_push(0, 16'h00AA, 16'h0000, 1'b1, 1'b0, 8'h44);
    cyc();
    // WAW on R6, then the same destination without a claim is accepted.
    drv(0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 3'd6);
    exp_push(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'h44);
    cyc();
    drv(0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd6);
    exp_push(0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h44);
    cyc();

    // Zero register: write and claim of R0 both ignored.
    drv(1, 3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 1'b1, 3'd0);
    exp_push(1, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h00);
    cyc();
    drv(1, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0);
    exp_push(1, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h00);
    cyc();

    // No bypass: a claimed register stalls for one cycle past its writeback.
    drv(1, 3'd1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 3'd2);
    exp_push(1, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h00);
    cyc();
    drv(1, 3'd2, 3'd0, 1'b1, 3'd2, 16'h5555, 1'b1, 1'b0, 3'd0);
    exp_push(1, 16'h0000, 16'h0000, 1'b1, 1'b0, 8'h04);
    cyc();
    drv(1, 3'd2, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0);
    exp_push(1, 16'h5555, 16'h0000, 1'b0, 1'b1, 8'h00);
    cyc();
    drv(1, 3'd0, 3'd0, 1'b1, 3'd2, 16'h6666, 1'b1, 1'b1, 3'd2);
    exp_push(1, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h00);
    cyc();
    drv(1, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    exp_push(1, 16'h6666, 16'h6666, 1'b0, 1'b0, 8'h04);
    cyc();

    // Build up state on dut0: claim R1, write R4.
    drv(0, 3'd0, 3'd0, 1'b1, 3'd4, 16'hBEEF, 1'b1, 1'b1, 3'd1);
    exp_push(0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h44);
    cyc();
    drv(0, 3'd4, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    exp_push(0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 8'h46);
    cyc();

    // Asynchronous reset between edges clears everything at once.
    rst = 1'b1;
    drv(0, 3'd4, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    exp_push(0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);
    drv(1, 3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    exp_push(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00);
    cyc();
    rst = 1'b0;

    // Writeback to a now-idle register lands without touching busy state.
    drv(0, 3'd1, 3'd4, 1'b1, 3'd1, 16'h0101, 1'b1, 1'b0, 3'd0);
    exp_push(0, 16'h0101, 16'h0000, 1'b0, 1'b1, 8'h00);
    cyc();
    drv(0, 3'd1, 3'd6, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0);
    exp_push(0, 16'h0101, 16'h0000, 1'b0, 1'b0, 8'h00);
    cyc();

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the CPU's 8x16 register file. It has two combinational read ports and one synchronous write port, plus optional write-to-read bypass and an optional hardwired zero register. A per-register busy-bit scoreboard tracks in-flight destination writes and flags RAW/WAW hazards to the issue logic. It sits between decode (read IDs, issue claim) and writeback (write port).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register ID width; depth = 2**ADDR_W
ZERO_REG, 0, 1 = register 0 always reads 0, writes to it ignored, never busy
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports and clears hazards

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
RS_ID  in  ADDR_W  read port 1 register ID
RT_ID  in  ADDR_W  read port 2 register ID
Reg_RData1  out  DATA_W  read data for RS_ID
Reg_RData2  out  DATA_W  read data for RT_ID
REG_W_ID  in  ADDR_W  writeback register ID
Reg_WE  in  1  writeback enable
Reg_WData  in  DATA_W  writeback data
Issue_Valid  in  1  decode requests to issue an instruction writing Issue_WID
Issue_WE  in  1  issuing instruction has a destination (claim Issue_WID)
Issue_WID  in  ADDR_W  destination register of issuing instruction
Issue_Accept  out  1  issue accepted this cycle
Hazard  out  1  RAW/WAW hazard; decode must stall
Busy_Vec  out  2**ADDR_W  current busy bits, bit i = register i

Behaviour:
- Clock and reset: one clock, CLK; reset RST is asynchronous and active-high.
- Reset: all registers are cleared to 0 and all busy bits to 0, immediately on RST assertion, independent of CLK. Outputs during reset: Reg_RData1/2 = 0 (unless bypass is active), Busy_Vec = 0, Hazard = 0, Issue_Accept = Issue_Valid. No state update on a clock edge while RST is high.
- Write: on the CLK rising edge with Reg_WE=1, Register[REG_W_ID] <= Reg_WData. If ZERO_REG=1 and REG_W_ID=0, the write is dropped.
- Read: combinational, zero latency.
  - Reg_RData1 = Register[RS_ID]; Reg_RData2 = Register[RT_ID].
  - BYPASS=1 and Reg_WE=1 and REG_W_ID==RS_ID (excluding zero reg): Reg_RData1 = Reg_WData. RT port identical.
  - ZERO_REG=1 and ID=0: data is 0 regardless of bypass.
- Effective busy:
  - eb[i] = busy[i] & ~(BYPASS & Reg_WE & REG_W_ID==i).
  - eb[0] = 0 when ZERO_REG=1.
- Hazard = Issue_Valid & (eb[RS_ID] | eb[RT_ID] | (Issue_WE & eb[Issue_WID])).
- Issue_Accept = Issue_Valid & ~Hazard.
- Busy update at posedge, evaluated in order; the later rule wins:
  1. Reg_WE=1 clears busy[REG_W_ID].
  2. Issue_Accept & Issue_WE sets busy[Issue_WID].
  - When both hit the same ID in one cycle, the set wins: busy stays 1 for the new claim.
  - ZERO_REG=1: busy[0] is never set.
- Writeback to a non-busy register: data is written normally; the busy bit stays 0. No error.
- BYPASS=0: hazards are cleared only by the registered busy bit, so reading a just-written register incurs a one-cycle stall.
- Reset mid-operation: all pending claims are discarded. Later writebacks land in the array but do not underflow busy state.

Test Plan:
- Reset then read all IDs -> every Reg_RData = 0x0000, Busy_Vec = 0x00, Hazard = 0.
- Write 0x007B to R3 (Reg_WE=1), same cycle RS_ID=3 with BYPASS=1 -> Reg_RData1 = 0x007B combinationally; next cycle, with Reg_WE=0, Reg_RData1 = 0x007B from the array.
- Issue Issue_WID=5 with Issue_WE=1 -> Busy_Vec = 0x20. Next issue with RS_ID=5 -> Hazard = 1, Issue_Accept = 0. Writeback R5=0x1234 that cycle (BYPASS=1) -> Hazard drops to 0, Reg_RData1 = 0x1234, accept; busy[5] ends at 0.
- Same-cycle writeback R2 and accepted issue claiming R2 -> busy[2] = 1 after the edge. Repeat with BYPASS=0 and RS_ID=2 while busy -> one stall cycle observed.
- ZERO_REG=1: write 0xFFFF to R0 and issue claiming R0 -> Reg_RData1(RS_ID=0) = 0, busy[0] = 0, no hazard.
- Set busy R1 and R6, write R4=0xBEEF, assert RST asynchronously between edges -> Busy_Vec = 0 and R4 reads 0 immediately, with no clock edge needed.
